// File: rtl/sensors_intf_pio_pkg.sv
// Shared register-map constants for the sensors-interface general-purpose PIO.
package sensors_intf_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd5;
  localparam logic [2:0] ADDR_OUTSET   = 3'd6;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd7;

endpackage

// File: rtl/sensors_intf_pio_sync.sv
// Per-bit pin synchroniser followed by one history flop for rise/fall detection.
module sensors_intf_pio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_data,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] r_chain [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_chain[i] <= '0;
      r_prev <= '0;
    end else begin
      r_chain[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) r_chain[i] <= r_chain[i-1];
      r_prev <= r_chain[SYNC_STAGES-1];
    end
  end

  assign sync_data = r_chain[SYNC_STAGES-1];
  assign rise      = sync_data & ~r_prev;
  assign fall      = ~sync_data & r_prev;

endmodule

// File: rtl/sensors_intf_pio_gen.sv
// Avalon-MM bidirectional PIO: register file, edge capture with W1C, read mux and level irq.
module sensors_intf_pio_gen
  import sensors_intf_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_en,
  output logic             irq
);

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [31:0]      r_readdata;

  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_cap_next;
  logic [31:0]      w_rd_mux;

  sensors_intf_pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .async_in  (in_port),
    .sync_data (w_sync),
    .rise      (w_rise),
    .fall      (w_fall)
  );

  assign w_wr    = chipselect & ~write_n;
  assign w_wdata = writedata[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_wd_upper
      logic w_unused_wd;
      assign w_unused_wd = ^writedata[31:WIDTH];
    end
  endgenerate

  // A newly detected edge wins over a simultaneous W1C of the same bit.
  assign w_clr      = (w_wr && (address == ADDR_EDGE_CAP)) ? w_wdata : '0;
  assign w_cap_next = (r_cap & ~w_clr) | (w_rise & r_rise_en) | (w_fall & r_fall_en);

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:     w_rd_mux[WIDTH-1:0] = w_sync;
      ADDR_DIR:      w_rd_mux[WIDTH-1:0] = r_dir;
      ADDR_IRQ_MASK: w_rd_mux[WIDTH-1:0] = r_mask;
      ADDR_EDGE_CAP: w_rd_mux[WIDTH-1:0] = r_cap;
      ADDR_RISE_EN:  w_rd_mux[WIDTH-1:0] = r_rise_en;
      ADDR_FALL_EN:  w_rd_mux[WIDTH-1:0] = r_fall_en;
      default:       w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out      <= OUT_RESET;
      r_dir      <= '0;
      r_mask     <= '0;
      r_cap      <= '0;
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_mux;
      r_cap      <= w_cap_next;
      if (w_wr) begin
        case (address)
          ADDR_DATA:     r_out     <= w_wdata;
          ADDR_DIR:      r_dir     <= w_wdata;
          ADDR_IRQ_MASK: r_mask    <= w_wdata;
          ADDR_RISE_EN:  r_rise_en <= w_wdata;
          ADDR_FALL_EN:  r_fall_en <= w_wdata;
          ADDR_OUTSET:   r_out     <= r_out | w_wdata;
          ADDR_OUTCLR:   r_out     <= r_out & ~w_wdata;
          default:       ;
        endcase
      end
    end
  end

  assign readdata = r_readdata;
  assign out_port = r_out;
  assign out_en   = r_dir;
  assign irq      = |(r_cap & r_mask);

endmodule

// File: tb/tb_sensors_intf_pio_gen.sv
// Directed plus randomized bench for the PIO, checked against a pin-history reference model.
module tb_sensors_intf_pio_gen;

  localparam int W  = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  wire  [31:0]   readdata;
  wire  [W-1:0]  out_port;
  wire  [W-1:0]  out_en;
  wire           irq;

  int checks = 0;
  int errors = 0;

  // Reference state: register contents plus the pin values sampled at recent edges.
  logic [W-1:0] m_out, m_dir, m_mask, m_cap, m_rise, m_fall;
  logic [31:0]  m_rd;
  logic [W-1:0] hist [0:SS];

  always #5 clk = ~clk;

  sensors_intf_pio_gen #(
    .WIDTH       (W),
    .SYNC_STAGES (SS),
    .OUT_RESET   ('0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .out_en     (out_en),
    .irq        (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_dir = '0; m_mask = '0; m_cap = '0; m_rise = '0; m_fall = '0;
    m_rd = '0;
    for (int i = 0; i <= SS; i++) hist[i] = '0;
  endtask

  // A pin sampled SS edges ago is the synchronised level; one edge older is its predecessor.
  task automatic model_edge();
    logic [W-1:0] s_now, s_before, clr, cap_n;
    logic         wr;
    s_now    = hist[SS-1];
    s_before = hist[SS];
    wr       = chipselect && !write_n;
    case (address)
      3'd0: m_rd = 32'(s_now);
      3'd1: m_rd = 32'(m_dir);
      3'd2: m_rd = 32'(m_mask);
      3'd3: m_rd = 32'(m_cap);
      3'd4: m_rd = 32'(m_rise);
      3'd5: m_rd = 32'(m_fall);
      default: m_rd = 32'd0;
    endcase
    clr   = (wr && address == 3'd3) ? writedata[W-1:0] : '0;
    cap_n = (m_cap & ~clr);
    for (int b = 0; b < W; b++) begin
      if (m_rise[b] && s_now[b] && !s_before[b]) cap_n[b] = 1'b1;
      if (m_fall[b] && !s_now[b] && s_before[b]) cap_n[b] = 1'b1;
    end
    if (wr) begin
      case (address)
        3'd0: m_out  = writedata[W-1:0];
        3'd1: m_dir  = writedata[W-1:0];
        3'd2: m_mask = writedata[W-1:0];
        3'd4: m_rise = writedata[W-1:0];
        3'd5: m_fall = writedata[W-1:0];
        3'd6: m_out  = m_out | writedata[W-1:0];
        3'd7: m_out  = m_out & ~writedata[W-1:0];
        default: ;
      endcase
    end
    m_cap = cap_n;
    for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = in_port;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("readdata", readdata, m_rd);
    chk("out_port", 32'(out_port), 32'(m_out));
    chk("out_en", 32'(out_en), 32'(m_dir));
    chk("irq", 32'(irq), 32'((m_cap & m_mask) != '0));
    @(negedge clk);
  endtask

  task automatic step(input logic [2:0] a, input bit w, input logic [31:0] d);
    address   = a;
    write_n   = !w;
    chipselect = w ? 1'b1 : 1'($urandom_range(0, 1));
    writedata = w ? d : $urandom;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset state on every address
    for (int a = 0; a < 8; a++) begin
      step(3'(a), 1'b0, 32'd0);
      chk("rst_read", readdata, 32'd0);
    end
    chk("rst_out_port", 32'(out_port), 32'd0);
    chk("rst_out_en", 32'(out_en), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);

    // Rising edge with mask, then W1C
    step(3'd4, 1'b1, 32'h01);
    step(3'd2, 1'b1, 32'h01);
    in_port = 8'h01;
    repeat (4) step(3'd3, 1'b0, 32'd0);
    chk("rise_cap", readdata, 32'h01);
    chk("rise_irq", 32'(irq), 32'd1);
    step(3'd0, 1'b0, 32'd0);
    chk("rise_data", readdata, 32'h01);
    step(3'd3, 1'b1, 32'h01);
    chk("w1c_irq", 32'(irq), 32'd0);
    step(3'd3, 1'b0, 32'd0);
    chk("w1c_cap", readdata, 32'd0);

    // Both edges on bit 7, then falling edge alone
    step(3'd4, 1'b1, 32'h80);
    step(3'd5, 1'b1, 32'h80);
    in_port = 8'h81;
    repeat (2) step(3'd3, 1'b0, 32'd0);
    in_port = 8'h01;
    repeat (2) step(3'd3, 1'b0, 32'd0);
    repeat (4) step(3'd3, 1'b0, 32'd0);
    chk("both_cap", readdata, 32'h80);
    step(3'd3, 1'b1, 32'h80);
    step(3'd4, 1'b1, 32'h00);
    in_port = 8'h81;
    repeat (4) step(3'd3, 1'b0, 32'd0);
    chk("rise_disabled", readdata, 32'h00);
    in_port = 8'h01;
    repeat (4) step(3'd3, 1'b0, 32'd0);
    chk("fall_only", readdata, 32'h80);

    // Set beats clear on bit 2
    step(3'd4, 1'b1, 32'h04);
    in_port = 8'h05;
    step(3'd0, 1'b0, 32'd0);
    step(3'd0, 1'b0, 32'd0);
    step(3'd3, 1'b1, 32'h04);
    step(3'd3, 1'b0, 32'd0);
    chk("set_beats_clr", readdata, 32'h84);

    // Output register and direction
    step(3'd0, 1'b1, 32'hA5);
    chk("out_data", 32'(out_port), 32'hA5);
    step(3'd6, 1'b1, 32'h0A);
    chk("out_set", 32'(out_port), 32'hAF);
    step(3'd7, 1'b1, 32'h81);
    chk("out_clr", 32'(out_port), 32'h2E);
    step(3'd1, 1'b1, 32'hF0);
    chk("dir", 32'(out_en), 32'hF0);

    // Masked-off capture, unselected bit, mask change, async reset
    chk("masked_irq0", 32'(irq), 32'd0);
    step(3'd4, 1'b1, 32'h10);
    in_port = 8'h35;
    repeat (4) step(3'd3, 1'b0, 32'd0);
    chk("masked_cap", readdata, 32'h94);
    chk("masked_irq", 32'(irq), 32'd0);
    step(3'd2, 1'b1, 32'h10);
    chk("mask_irq_on", 32'(irq), 32'd1);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_irq", 32'(irq), 32'd0);
    chk("arst_read", readdata, 32'd0);
    chk("arst_out_port", 32'(out_port), 32'd0);
    chk("arst_out_en", 32'(out_en), 32'd0);
    in_port = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) step(3'd3, 1'b0, 32'd0);
    chk("high_at_release", readdata, 32'd0);
    step(3'd0, 1'b0, 32'd0);
    chk("data_after_release", readdata, 32'hFF);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ W'(1 << $urandom_range(0, W-1));
      if ($urandom_range(0, 15) == 0) in_port = W'($urandom);
      step(3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
